// File: rtl/des_pkg.sv
// Shared DES package: permutation tables, shift schedule, width constants,
// key-schedule state encoding and small bit-manipulation helpers.
package des_pkg;

  localparam int DES_KEY_W    = 64;
  localparam int DES_CD_W     = 28;
  localparam int DES_SUBKEY_W = 48;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } des_ks_state_e;

  // PC-1, 1-based DES bit numbering (bit 1 = MSB of the 64-bit key).
  localparam logic [6:0] PC1_TABLE [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // PC-2, 1-based numbering over the 56-bit C||D word.
  localparam logic [5:0] PC2_TABLE [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Left-shift amounts S(1)..S(16), stored at index r-1.
  localparam logic [1:0] SHIFT_TABLE [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Shift amount for round r (1..16).
  function automatic logic [1:0] shift_for_round(input logic [4:0] r);
    logic [3:0] idx;
    idx = 4'(r - 5'd1);
    return SHIFT_TABLE[idx];
  endfunction

  // PC-1: 64-bit key to 56-bit C0||D0; parity bits simply never get selected.
  function automatic logic [55:0] pc1_apply(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  src;
    logic [5:0]  dst;
    r = 56'd0;
    for (int i = 0; i < 56; i++) begin
      dst    = 6'(55 - i);
      src    = 6'(7'd64 - PC1_TABLE[6'(i)]);
      r[dst] = k[src];
    end
    return r;
  endfunction

  // 28-bit rotate left by 1 or 2.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] r;
    case (amt)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  // 28-bit rotate right by 1 or 2.
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] r;
    case (amt)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit C||D to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  // Pure wiring permutation; output bit 1 (MSB) is selected by PC2_TABLE[0].
  always_comb begin : pc2_perm
    logic [5:0] src;
    logic [5:0] dst;
    subkey = 48'd0;
    src    = 6'd0;
    dst    = 6'd0;
    for (int j = 0; j < 48; j++) begin
      dst         = 6'(47 - j);
      src         = 6'(7'd56 - {1'b0, PC2_TABLE[6'(j)]});
      subkey[dst] = cd[src];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Streaming DES key schedule: loads a key once, then emits the sixteen
// round subkeys one per handshake, forward for encrypt, reversed for decrypt.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_round,
  output logic        done
);

  des_ks_state_e state_r, state_nxt;
  logic [27:0]   c_r, c_nxt;
  logic [27:0]   d_r, d_nxt;
  logic [3:0]    n_r, n_nxt;
  logic [3:0]    round_r, round_nxt;
  logic          mode_r, mode_nxt;
  logic          done_r, done_nxt;
  logic          key_ready_r;
  logic          subkey_valid_r;

  logic [55:0]   cd0_s;
  logic          key_hs_s;
  logic          sub_hs_s;
  logic [1:0]    enc_shift_s;
  logic [1:0]    dec_shift_s;

  // PC-1 is only needed at load time, so it sits directly on the key input.
  assign cd0_s    = pc1_apply(key);
  assign key_hs_s = key_valid & key_ready_r;
  assign sub_hs_s = subkey_valid_r & subkey_ready;

  // Encrypt moves from round n+1 to n+2; decrypt undoes the shift of round 16-n.
  assign enc_shift_s = shift_for_round(5'({1'b0, n_r}) + 5'd2);
  assign dec_shift_s = shift_for_round(5'd16 - {1'b0, n_r});

  // Next-state, C/D rotation and round index bookkeeping.
  always_comb begin
    state_nxt = state_r;
    c_nxt     = c_r;
    d_nxt     = d_r;
    n_nxt     = n_r;
    round_nxt = round_r;
    mode_nxt  = mode_r;
    done_nxt  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (key_hs_s) begin
          state_nxt = ST_EMIT;
          mode_nxt  = decrypt;
          n_nxt     = 4'd0;
          if (decrypt) begin
            // Total rotation over 16 rounds is 28, so C16/D16 equal C0/D0.
            c_nxt     = cd0_s[55:28];
            d_nxt     = cd0_s[27:0];
            round_nxt = 4'd15;
          end else begin
            c_nxt     = rotl28(cd0_s[55:28], 2'd1);
            d_nxt     = rotl28(cd0_s[27:0], 2'd1);
            round_nxt = 4'd0;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (sub_hs_s) begin
          if (n_r == 4'd15) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            n_nxt = n_r + 4'd1;
            if (mode_r) begin
              c_nxt     = rotr28(c_r, dec_shift_s);
              d_nxt     = rotr28(d_r, dec_shift_s);
              round_nxt = round_r - 4'd1;
            end else begin
              c_nxt     = rotl28(c_r, enc_shift_s);
              d_nxt     = rotl28(d_r, enc_shift_s);
              round_nxt = round_r + 4'd1;
            end
          end
        end else begin
          state_nxt = ST_EMIT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake flags are registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      c_r            <= 28'd0;
      d_r            <= 28'd0;
      n_r            <= 4'd0;
      round_r        <= 4'd0;
      mode_r         <= 1'b0;
      done_r         <= 1'b0;
      key_ready_r    <= 1'b0;
      subkey_valid_r <= 1'b0;
    end else begin
      state_r        <= state_nxt;
      c_r            <= c_nxt;
      d_r            <= d_nxt;
      n_r            <= n_nxt;
      round_r        <= round_nxt;
      mode_r         <= mode_nxt;
      done_r         <= done_nxt;
      key_ready_r    <= (state_nxt == ST_IDLE);
      subkey_valid_r <= (state_nxt == ST_EMIT);
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_r, d_r}),
    .subkey (subkey)
  );

  assign key_ready    = key_ready_r;
  assign subkey_valid = subkey_valid_r;
  assign subkey_round = round_r;
  assign done         = done_r;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed testbench for des_key_schedule using the classic DES example key.
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        decrypt;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  subkey_round;
  logic        done;

  int pass_cnt;
  int check_cnt;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h123456789ABCDEF0;

  // K1..K16 for KEY_A, hand-derived from the textbook DES worked example.
  localparam logic [47:0] EXP [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key          (key),
    .decrypt      (decrypt),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_round (subkey_round),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load one key and drain its 16 subkeys, optionally with random backpressure.
  task automatic run_key(input logic [63:0] k, input logic dec, input bit stall);
    int          got;
    int          budget;
    int          idx;
    logic [47:0] prev_key;
    logic [3:0]  prev_round;
    bit          prev_stall;
    key = k; decrypt = dec; key_valid = 1'b1; subkey_ready = 1'b0;
    budget = 0;
    while (!key_ready && budget < 50) begin
      step();
      budget++;
    end
    check_eq("key_ready_before_load", 64'(key_ready), 64'd1);
    step();
    key_valid = 1'b0;
    key = 64'hDEADBEEFCAFEF00D;
    decrypt = ~dec;
    check_eq("first_valid_latency", 64'(subkey_valid), 64'd1);
    got = 0; budget = 0; prev_stall = 1'b0;
    prev_key = 48'd0; prev_round = 4'd0;
    while (got < 16 && budget < 300) begin
      if (prev_stall) begin
        check_eq("stall_subkey_stable", 64'(subkey), 64'(prev_key));
        check_eq("stall_round_stable", 64'(subkey_round), 64'(prev_round));
      end
      idx = dec ? 15 - got : got;
      subkey_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (subkey_valid && subkey_ready) begin
        check_eq("subkey", 64'(subkey), 64'(EXP[idx]));
        check_eq("subkey_round", 64'(subkey_round), 64'(idx));
        got++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = subkey_valid;
        prev_key   = subkey;
        prev_round = subkey_round;
      end
      step();
      budget++;
    end
    subkey_ready = 1'b0;
    check_eq("handshake_count", 64'(got), 64'd16);
    check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("key_ready_with_done", 64'(key_ready), 64'd1);
    check_eq("valid_low_after_run", 64'(subkey_valid), 64'd0);
    step();
    check_eq("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    pass_cnt = 0; check_cnt = 0;
    rst = 1'b1; key_valid = 1'b0; key = 64'd0; decrypt = 1'b0; subkey_ready = 1'b0;

    // Reset state.
    step();
    check_eq("rst_key_ready", 64'(key_ready), 64'd0);
    check_eq("rst_subkey_valid", 64'(subkey_valid), 64'd0);
    check_eq("rst_subkey", 64'(subkey), 64'd0);
    check_eq("rst_round", 64'(subkey_round), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();
    check_eq("key_ready_after_rst", 64'(key_ready), 64'd1);

    // Streaming encrypt and decrypt, stalled encrypt, parity-only key variant.
    run_key(KEY_A, 1'b0, 1'b0);
    run_key(KEY_A, 1'b1, 1'b0);
    run_key(KEY_A, 1'b0, 1'b1);
    run_key(KEY_A, 1'b1, 1'b1);
    run_key(KEY_B, 1'b0, 1'b0);

    // Reset abort at the 7th subkey.
    key = KEY_A; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
    step();
    key_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_eq("abort_pre_subkey", 64'(subkey), 64'(EXP[6]));
    check_eq("abort_pre_round", 64'(subkey_round), 64'd6);
    rst = 1'b1;
    step();
    check_eq("abort_valid", 64'(subkey_valid), 64'd0);
    check_eq("abort_round", 64'(subkey_round), 64'd0);
    check_eq("abort_subkey", 64'(subkey), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();
    check_eq("abort_no_done", 64'(done), 64'd0);
    check_eq("abort_key_ready", 64'(key_ready), 64'd1);
    run_key(KEY_A, 1'b0, 1'b0);

    // Back-to-back keys with key_valid held; key/decrypt churn during EMIT.
    key = KEY_A; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
    step();
    key = KEY_B; decrypt = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("b2b_first_subkey", 64'(subkey), 64'(EXP[i]));
      check_eq("b2b_first_round", 64'(subkey_round), 64'(i));
      step();
    end
    check_eq("b2b_done", 64'(done), 64'd1);
    check_eq("b2b_key_ready", 64'(key_ready), 64'd1);
    step();
    key_valid = 1'b0;
    check_eq("b2b_second_valid", 64'(subkey_valid), 64'd1);
    check_eq("b2b_second_first", 64'(subkey), 64'(EXP[15]));
    check_eq("b2b_second_round", 64'(subkey_round), 64'd15);
    for (int i = 1; i < 16; i++) begin
      step();
      check_eq("b2b_second_subkey", 64'(subkey), 64'(EXP[15 - i]));
    end
    step();
    check_eq("b2b_second_done", 64'(done), 64'd1);
    subkey_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
